// File: rtl/seq_mult_issue_ctrl.sv
// Queues operand pairs, issues each one to the external shift multiplier, and holds its product behind valid/ready.
// A pair accepted into an idle, empty block is presented MULT_CYCLES+2 cycles later; a held result stalls new issues.
module seq_mult_issue_ctrl #(
   parameter int WIDTH       = 6,
   parameter int DEPTH       = 4,
   parameter int MULT_CYCLES = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   output logic                     mult_load,
   output logic [WIDTH-1:0]         mult_a,
   output logic [WIDTH-1:0]         mult_b,
   input  logic [2*WIDTH-1:0]       mult_product,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*WIDTH-1:0]       out_product,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_count;
   logic [2*WIDTH-1:0]    r_mem [DEPTH];
   logic                  r_mult_load;
   logic [WIDTH-1:0]      r_mult_a;
   logic [WIDTH-1:0]      r_mult_b;
   logic                  r_out_valid;
   logic [2*WIDTH-1:0]    r_out_product;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_capture;
   logic                  w_empty;
   logic                  w_out_free;
   logic [2*WIDTH-1:0]    w_head;

   // in_ready comes from registered occupancy only, so a same-edge pop never frees a slot early
   assign in_ready    = (r_count != (AW+1)'(DEPTH));
   assign w_push      = in_valid & in_ready;
   assign w_empty     = (r_count == '0);
   assign w_out_free  = ~r_out_valid | out_ready;
   assign w_head      = r_mem[r_rd_ptr];

   assign mult_load   = r_mult_load;
   assign mult_a      = r_mult_a;
   assign mult_b      = r_mult_b;
   assign out_valid   = r_out_valid;
   assign out_product = r_out_product;
   assign fifo_count  = r_count;
   assign busy        = (r_state != S_IDLE) | ~w_empty | r_out_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && w_out_free) begin
               w_pop       = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (r_cnt == CW'(MULT_CYCLES - 1)) begin
               w_capture   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_LOAD) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Storage carries data only; validity lives in the pointers and count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_a, in_b};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Operands stay stable after LOAD so the multiplier may sample them late
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mult_load <= 1'b0;
         r_mult_a    <= '0;
         r_mult_b    <= '0;
      end else begin
         r_mult_load <= w_pop;
         if (w_pop) begin
            r_mult_a <= w_head[2*WIDTH-1:WIDTH];
            r_mult_b <= w_head[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_out_product <= '0;
      end else if (w_capture) begin
         r_out_valid   <= 1'b1;
         r_out_product <= mult_product;
      end else if (r_out_valid && out_ready) begin
         r_out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_mult_issue_ctrl.sv
// Directed bench for seq_mult_issue_ctrl with a cycle-accurate model of the shift multiplier.
module tb_seq_mult_issue_ctrl;

   localparam int W  = 6;
   localparam int MC = 7;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_a;
   logic [W-1:0]    in_b;
   logic            mult_load;
   logic [W-1:0]    mult_a;
   logic [W-1:0]    mult_b;
   logic [2*W-1:0]  mult_product;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  out_product;
   logic            busy;
   logic [2:0]      fifo_count;

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int cyc    = 0;
   int load_cnt = 0;

   seq_mult_issue_ctrl #(.WIDTH(W), .DEPTH(4), .MULT_CYCLES(MC)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mult_load(mult_load), .mult_a(mult_a), .mult_b(mult_b), .mult_product(mult_product),
      .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
      .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mult_load) load_cnt <= load_cnt + 1;
   end

   // Multiplier model: product is correct only from the cycle before load edge + MC, corrupted earlier
   logic [W-1:0]   m_a, m_b;
   int             m_cnt;
   logic [2*W-1:0] m_true;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_a <= '0; m_b <= '0; m_cnt <= 100;
      end else if (mult_load) begin
         m_a <= mult_a; m_b <= mult_b; m_cnt <= 0;
      end else if (m_cnt < 100) begin
         m_cnt <= m_cnt + 1;
      end
   end
   assign m_true       = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
   assign mult_product = (m_cnt >= MC - 1) ? m_true : (m_true ^ 12'h5A5);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
      bit ok = 1'b0;
      in_valid = 1'b1; in_a = a; in_b = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = in_ready;
         @(negedge clk);
      end
      in_valid = 1'b0;
      acc = cyc;
      check("push_accept", ok, 1);
   endtask

   task automatic wait_out(input logic [2*W-1:0] exp, input int acc, input int lat, input string tag);
      bit seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check({tag, "_seen"}, seen, 1);
      if (seen) begin
         check({tag, "_prod"}, out_product, exp);
         if (lat >= 0) check({tag, "_lat"}, cyc - acc, lat);
      end
   endtask

   typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [2*W-1:0] p; } vec_t;

   initial begin
      int acc;
      int acc0;
      int l0;
      vec_t b2b[4];
      vec_t bp[6];
      b2b[0] = '{13, 20, 260}; b2b[1] = '{12, 24, 288};
      b2b[2] = '{63, 63, 3969}; b2b[3] = '{0, 45, 0};
      bp[0] = '{1, 2, 2};   bp[1] = '{3, 4, 12};  bp[2] = '{5, 6, 30};
      bp[3] = '{7, 8, 56};  bp[4] = '{9, 10, 90}; bp[5] = '{11, 12, 132};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_count", fifo_count, 0);
      check("rst_load", mult_load, 0);
      check("rst_mult_a", mult_a, 0);
      check("rst_mult_b", mult_b, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_product", out_product, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single operation
      push(13, 20, acc);
      check("single_no_bypass", mult_load, 0);
      check("single_count1", fifo_count, 1);
      check("single_busy", busy, 1);
      @(negedge clk);
      check("single_load_hi", mult_load, 1);
      check("single_mult_a", mult_a, 13);
      check("single_mult_b", mult_b, 20);
      check("single_count0", fifo_count, 0);
      @(negedge clk);
      check("single_load_lo", mult_load, 0);
      wait_out(260, acc, MC + 2, "single");
      @(negedge clk);
      check("single_fall", out_valid, 0);
      check("single_idle", busy, 0);

      // Back-to-back issue with the consumer always ready
      l0 = load_cnt;
      push(b2b[0].a, b2b[0].b, acc0);
      for (int i = 1; i < 4; i++) push(b2b[i].a, b2b[i].b, acc);
      for (int i = 0; i < 4; i++) wait_out(b2b[i].p, acc0, (MC + 2) * (i + 1), "b2b");
      check("b2b_loads", load_cnt - l0, 4);
      @(negedge clk);
      check("b2b_idle", busy, 0);

      // Backpressure: fill FIFO behind one in-flight pair
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(bp[i].a, bp[i].b, acc);
      check("bp_full_count", fifo_count, 4);
      check("bp_full_rdy", in_ready, 0);
      in_valid = 1'b1; in_a = bp[5].a; in_b = bp[5].b;
      repeat (12) @(negedge clk);
      check("bp_hold_count", fifo_count, 4);
      check("bp_hold_rdy", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_prod", out_product, bp[0].p);
      repeat (3) @(negedge clk);
      check("bp_stable_valid", out_valid, 1);
      check("bp_stable_prod", out_product, bp[0].p);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_consumed", out_valid, 0);
      check("bp_pop_count", fifo_count, 3);
      check("bp_rdy_rise", in_ready, 1);
      check("bp_reissue", mult_load, 1);
      check("bp_reissue_a", mult_a, bp[1].a);
      @(negedge clk);
      check("bp_sixth_in", fifo_count, 4);
      in_valid = 1'b0;
      for (int i = 1; i < 6; i++) wait_out(bp[i].p, 0, -1, "bp_drain");
      @(negedge clk);
      check("bp_idle", busy, 0);

      // Push and pop on the same edge at occupancy 2
      out_ready = 1'b0;
      push(2, 3, acc0);
      push(4, 5, acc);
      push(6, 7, acc);
      check("pp_pre_count", fifo_count, 2);
      wait_out(6, acc0, MC + 2, "pp_first");
      in_valid = 1'b1; in_a = 8; in_b = 9; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("pp_count", fifo_count, 2);
      check("pp_load", mult_load, 1);
      check("pp_mult_a", mult_a, 4);
      wait_out(20, 0, -1, "pp_r2");
      wait_out(42, 0, -1, "pp_r3");
      wait_out(72, 0, -1, "pp_r4");
      @(negedge clk);
      check("pp_idle", busy, 0);

      // Reset in WAIT with a pair still queued
      push(12, 24, acc);
      push(3, 3, acc);
      check("rw_load", mult_load, 1);
      check("rw_count", fifo_count, 1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rw_out_valid", out_valid, 0);
      check("rw_count0", fifo_count, 0);
      check("rw_load0", mult_load, 0);
      check("rw_busy", busy, 0);
      check("rw_mult_a", mult_a, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset during LOAD drops the strobe at once; input ignored while in reset
      push(1, 1, acc);
      @(negedge clk);
      check("rl_load_hi", mult_load, 1);
      rst = 1'b1;
      #1;
      check("rl_load_drop", mult_load, 0);
      in_valid = 1'b1; in_a = 9; in_b = 9;
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      check("rl_ignore_in", fifo_count, 0);
      @(negedge clk);

      push(5, 7, acc);
      wait_out(35, acc, MC + 2, "post_rst");
      @(negedge clk);

      // Zero product still raises out_valid
      push(0, 0, acc);
      wait_out(0, acc, MC + 2, "zero");
      @(negedge clk);
      check("final_idle", busy, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
